// File: rtl/reconfig_responder.sv
// Reconfiguration request responder: arms on cfg_ENA, validates and times image loads.
// Optional enable-setup check is built when RECFG_SETUP_CHECK_EN is defined.
module reconfig_responder #(
    parameter int unsigned LOAD_CYCLES = 16,
    parameter logic [3:0]  VALID_MASK  = 4'b1111
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cfg_ENA,
    input  logic [1:0] cfg_CBSEL,
    input  logic       cfg_CONFIG,
    output logic       cfg_ERROR,
    output logic       busy,
    output logic       load_done,
    output logic [1:0] active_image,
    output logic [7:0] req_count
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IMG_W = 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic               cfg_config_q;
    logic               cfg_error_q, cfg_error_d;
    logic               busy_q, busy_d;
    logic               load_done_q, load_done_d;
    logic [IMG_W-1:0]   active_image_q, active_image_d;
    logic [IMG_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   req_count_q, req_count_d;
    logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
    logic               trigger_c;
    logic               setup_ok_c;

    assign trigger_c = cfg_CONFIG & ~cfg_config_q;

`ifdef RECFG_SETUP_CHECK_EN
    localparam int unsigned SETUP_W = 3;
    // Three completed ARMED cycles plus the current one give four enabled cycles.
    localparam logic [SETUP_W-1:0] SETUP_MIN = SETUP_W'(3);

    logic [SETUP_W-1:0] setup_q, setup_d;

    assign setup_ok_c = (setup_q >= SETUP_MIN);
`else
    assign setup_ok_c = 1'b1;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cfg_error_d    = cfg_error_q;
        busy_d         = busy_q;
        load_done_d    = 1'b0;
        active_image_d = active_image_q;
        sel_d          = sel_q;
        req_count_d    = req_count_q;
        load_cnt_d     = load_cnt_q;
`ifdef RECFG_SETUP_CHECK_EN
        setup_d        = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cfg_ENA) state_d = S_ARMED;
            end
            S_ARMED: begin
`ifdef RECFG_SETUP_CHECK_EN
                setup_d = (setup_q == '1) ? setup_q : setup_q + SETUP_W'(1);
`endif
                if (!cfg_ENA) begin
                    state_d = S_IDLE;
                end else if (trigger_c) begin
                    if (VALID_MASK[cfg_CBSEL] && setup_ok_c) begin
                        state_d    = S_LOAD;
                        busy_d     = 1'b1;
                        load_cnt_d = '0;
                        sel_d      = cfg_CBSEL;
                        if (req_count_q != REQ_MAX) req_count_d = req_count_q + CNT_W'(1);
                    end else begin
                        state_d     = S_ERROR;
                        cfg_error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // Abort wins over completion on the final load cycle.
                if (!cfg_ENA) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (load_cnt_q == LAST_CNT) begin
                    state_d        = S_DONE;
                    busy_d         = 1'b0;
                    load_done_d    = 1'b1;
                    active_image_d = sel_q;
                end else begin
                    load_cnt_d = load_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!cfg_ENA) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (!cfg_ENA) begin
                    state_d     = S_IDLE;
                    cfg_error_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            cfg_config_q   <= 1'b0;
            cfg_error_q    <= 1'b0;
            busy_q         <= 1'b0;
            load_done_q    <= 1'b0;
            active_image_q <= '0;
            sel_q          <= '0;
            req_count_q    <= '0;
            load_cnt_q     <= '0;
`ifdef RECFG_SETUP_CHECK_EN
            setup_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cfg_config_q   <= cfg_CONFIG;
            cfg_error_q    <= cfg_error_d;
            busy_q         <= busy_d;
            load_done_q    <= load_done_d;
            active_image_q <= active_image_d;
            sel_q          <= sel_d;
            req_count_q    <= req_count_d;
            load_cnt_q     <= load_cnt_d;
`ifdef RECFG_SETUP_CHECK_EN
            setup_q        <= setup_d;
`endif
        end
    end

    assign cfg_ERROR    = cfg_error_q;
    assign busy         = busy_q;
    assign load_done    = load_done_q;
    assign active_image = active_image_q;
    assign req_count    = req_count_q;

endmodule

// File: doc/reconfig_responder.md
RECONFIG_RESPONDER -- requirements
Module: reconfig_responder

Interface
REQ-001 Parameter: LOAD_CYCLES, default 16, number of cycles spent in LOAD per accepted request (legal 1..255).
REQ-002 Parameter: VALID_MASK, 4 bits, default 4'b1111, bit n set means image n is loadable.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rstn  input  1  reset, synchronous, active-low.
REQ-005 Port: cfg_ENA  input  1  reconfiguration enable from the initiator.
REQ-006 Port: cfg_CBSEL  input  2  requested image index.
REQ-007 Port: cfg_CONFIG  input  1  reconfiguration trigger; the rising edge is significant.
REQ-008 Port: cfg_ERROR  output  1  request rejected; sticky until cfg_ENA falls.
REQ-009 Port: busy  output  1  high while state is LOAD.
REQ-010 Port: load_done  output  1  one-cycle pulse when a load completes.
REQ-011 Port: active_image  output  2  index of the last successfully loaded image.
REQ-012 Port: req_count  output  8  count of accepted requests, saturating at 255.

Function
REQ-013 The block SHALL implement states IDLE, ARMED, LOAD, DONE, ERROR.
REQ-014 Trigger SHALL be defined as: cfg_CONFIG sampled 1 this cycle and 0 in the previous cycle, using one registered copy of cfg_CONFIG.
REQ-015 IDLE SHALL move to ARMED on the next edge after cfg_ENA is sampled 1.
REQ-016 In ARMED, cfg_ENA=0 SHALL return the block to IDLE; this check takes priority over the trigger.
REQ-017 In ARMED, a trigger with VALID_MASK[cfg_CBSEL]=1 SHALL latch cfg_CBSEL and enter LOAD on the next edge, with busy=1 and the load counter cleared.
REQ-018 In ARMED, a trigger with VALID_MASK[cfg_CBSEL]=0 SHALL enter ERROR on the next edge, with cfg_ERROR=1.
REQ-019 LOAD SHALL last exactly LOAD_CYCLES cycles; on exit, load_done SHALL pulse for 1 cycle, active_image SHALL take the latched index, and the state SHALL become DONE with busy=0.
REQ-020 req_count SHALL increment on entry to LOAD and SHALL saturate at 255 (no wrap).
REQ-021 Triggers and cfg_CBSEL changes during LOAD, DONE or ERROR SHALL be ignored.
REQ-022 cfg_ENA=0 sampled during LOAD SHALL abort to IDLE on the next edge: busy=0, no load_done, active_image unchanged, req_count retains its increment.
REQ-023 DONE and ERROR SHALL return to IDLE on the edge after cfg_ENA is sampled 0; cfg_ERROR clears at that same edge.
REQ-024 If the trigger and the final LOAD cycle are not concurrent events, a trigger coincident with any LOAD cycle SHALL still be ignored; a new request requires cfg_ENA to fall and rise again.

Reset
REQ-025 When rstn is sampled 0, the block SHALL set: state IDLE, cfg_ERROR=0, busy=0, load_done=0, active_image=2'b00, req_count=0, load counter 0, and the registered cfg_CONFIG to 0.
REQ-026 Reset during LOAD SHALL cancel the load with no load_done pulse; rstn SHALL take priority over every other input.

Configuration
REQ-027 The macro RECFG_SETUP_CHECK_EN SHALL control an enable-setup check.
REQ-028 When RECFG_SETUP_CHECK_EN is defined:
- a trigger in ARMED with fewer than 4 consecutive cycles of cfg_ENA=1 (counted from the first ARMED cycle) SHALL enter ERROR, regardless of VALID_MASK.
- the setup counter is 3 bits, saturating, and clears in IDLE.
REQ-029 When RECFG_SETUP_CHECK_EN is undefined, the setup counter SHALL NOT be built, and the trigger SHALL be accepted on any ARMED cycle.

Verification
REQ-030 Valid load, defaults: cfg_ENA=1 for 6 cycles, CBSEL=2, CONFIG rises -> busy=1 for exactly 16 cycles, then load_done pulses once, active_image=2, req_count=1.
REQ-031 Invalid image, VALID_MASK=4'b0111: trigger with CBSEL=3 -> cfg_ERROR=1 next cycle and held until cfg_ENA drops; active_image and req_count unchanged.
REQ-032 Abort: cfg_ENA drops at LOAD cycle 5 -> IDLE next cycle, busy=0, no load_done, active_image unchanged.
REQ-033 Mid-load reset: rstn=0 at LOAD cycle 8 -> all outputs at reset values on the next edge; no load_done pulse afterwards.
REQ-034 Saturation: 260 valid requests with LOAD_CYCLES=1 -> req_count stops at 255.
REQ-035 Setup check with RECFG_SETUP_CHECK_EN defined: trigger on the 2nd ARMED cycle -> cfg_ERROR=1; with the macro undefined, the same stimulus -> LOAD and load_done.
